// File: rtl/multi_port_ack_controller.sv
// multi_port_ack_controller: per-port read/write ack FSMs with settle delay, free-space check,
// timeout error pulse, abort on req drop and a busy flag.
module multi_port_ack_controller #(
   parameter int NPORTS       = 4,
   parameter int FIFO_DEPTH   = 16,
   parameter int LVL_W        = $clog2(FIFO_DEPTH) + 1,
   parameter int STATUS_DELAY = 3,
   parameter int RD_FREE_MIN  = 1,
   parameter int TIMEOUT      = 255
) (
   input  logic                      aclk,
   input  logic                      aresetn,
   input  logic [NPORTS-1:0]         req,
   input  logic [NPORTS-1:0]         cmd,
   input  logic [NPORTS-1:0]         rd_ack,
   input  logic [NPORTS*LVL_W-1:0]   fifo_level,
   output logic [NPORTS-1:0]         ack,
   output logic [NPORTS-1:0]         err,
   output logic [NPORTS-1:0]         busy
);
   localparam int ST_W = $clog2(STATUS_DELAY + 1);
   localparam int WT_W = TIMEOUT < 2 ? 1 : $clog2(TIMEOUT);
   localparam logic [ST_W-1:0]  ST_LAST  = ST_W'(STATUS_DELAY);
   localparam logic [WT_W-1:0]  WT_LAST  = WT_W'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);
   localparam logic [LVL_W-1:0] DEPTH    = LVL_W'(FIFO_DEPTH);
   localparam logic [LVL_W-1:0] FREE_MIN = LVL_W'(RD_FREE_MIN);

   typedef enum logic [2:0] {IDLE, WAIT_REQ_HIGH, RD_SETTLE, RD_CHECK, WR_WAIT, WAIT_REQ_LOW} state_t;

   for (genvar g = 0; g < NPORTS; g++) begin : ch
      state_t           state_q, state_d;
      logic [ST_W-1:0]  st_q, st_d;
      logic [WT_W-1:0]  wt_q, wt_d;
      logic [LVL_W-1:0] lvl_q, free;
      logic             ack_q, ack_d, err_q, err_d, ok, tmo;

      // an over-full level reports zero free words instead of wrapping
      assign free = lvl_q > DEPTH ? '0 : DEPTH - lvl_q;
      assign ok   = state_q == RD_CHECK ? free >= FREE_MIN : rd_ack[g];
      assign tmo  = TIMEOUT != 0 && wt_q == WT_LAST;

      always_comb begin
         state_d = state_q;
         st_d    = st_q;
         wt_d    = wt_q;
         ack_d   = 1'b0;
         err_d   = 1'b0;
         case (state_q)
            IDLE:          state_d = WAIT_REQ_HIGH;
            WAIT_REQ_HIGH: if (req[g]) begin
               state_d = cmd[g] ? WR_WAIT : RD_SETTLE;
               st_d    = '0;
               wt_d    = '0;
            end
            RD_SETTLE:     if (!req[g]) state_d = WAIT_REQ_HIGH;
                           else if (st_q == ST_LAST) begin
                              state_d = RD_CHECK;
                              wt_d    = '0;
                           end else st_d = st_q + ST_W'(1);
            RD_CHECK, WR_WAIT: if (!req[g]) state_d = WAIT_REQ_HIGH;
                           else if (ok) begin
                              ack_d   = 1'b1;
                              state_d = WAIT_REQ_LOW;
                           end else if (tmo) begin
                              err_d   = 1'b1;
                              state_d = WAIT_REQ_LOW;
                           end else wt_d = wt_q == '1 ? wt_q : wt_q + WT_W'(1);
            WAIT_REQ_LOW:  if (!req[g]) state_d = WAIT_REQ_HIGH;
            default:       state_d = IDLE;
         endcase
      end

      always_ff @(posedge aclk) begin
         if (!aresetn) begin
            state_q <= IDLE;
            st_q    <= '0;
            wt_q    <= '0;
            lvl_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
         end else begin
            state_q <= state_d;
            st_q    <= st_d;
            wt_q    <= wt_d;
            lvl_q   <= fifo_level[g*LVL_W +: LVL_W];
            ack_q   <= ack_d;
            err_q   <= err_d;
         end
      end

      assign ack[g]  = ack_q;
      assign err[g]  = err_q;
      assign busy[g] = state_q != IDLE && state_q != WAIT_REQ_HIGH;
   end
endmodule
